// File: rtl/line_select_seq.sv
// line_select_seq: picks one record out of N flattened input channels and
// presents it on a registered valid/ready output. The channel comes either
// from a manual select/load strobe or from an auto-rotating index that moves
// one channel forward every `dwell` cycles. If the output is blocked when an
// auto advance is due, the advance waits in a stall state.
//
// Handshake: out_valid/out_data/out_idx are driven only by this block; a
// record is consumed on any rising edge where out_valid && out_ready. While
// out_valid && !out_ready the record and index are held unchanged. The output
// register is "open" (a new capture may be loaded) when !out_valid ||
// out_ready. A capture on the same edge as a consumption replaces the record.
module line_select_seq #(
    parameter int W       = 77,
    parameter int N       = 13,
    parameter int SELW    = 4,
    parameter int DWELL_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N*W-1:0]      in_bus,
    input  logic [SELW-1:0]     sel,
    input  logic                load,
    input  logic                auto_en,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic [SELW-1:0]     out_idx,
    output logic                sel_err,
    output logic                overrun,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_MAN   = 2'd0,
        S_AUTO  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    // N in a width one bit wider than sel, so sel >= N works even when
    // N == 2**SELW.
    localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
    // Index of the last channel; the rotation wraps by comparing against
    // this rather than relying on counter overflow.
    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    state_t              state;
    logic [DWELL_W-1:0]  cnt;
    logic [SELW-1:0]     pend_idx;

    logic                open;
    logic                sel_ok;
    logic [SELW-1:0]     nxt_idx;
    logic [DWELL_W-1:0]  dwell_last;
    logic                tick;
    logic [W-1:0]        man_rec;
    logic [W-1:0]        adv_rec;
    logic [W-1:0]        pend_rec;

    // Channel slice selected by idx; indices >= N give zero (never captured).
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                          input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                r = bus[k*W +: W];
            end
        end
        return r;
    endfunction

    assign state_dbg = state;

    // Shared decode: open window, select validity, next rotation index,
    // dwell compare (dwell of 0 behaves as 1) and the three candidate records.
    always_comb begin
        open       = !out_valid || out_ready;
        sel_ok     = ({1'b0, sel} < N_EXT);
        nxt_idx    = (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
        dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;
        // >= so that shrinking dwell below the running count ticks at once.
        tick       = (cnt >= dwell_last);
        man_rec    = pick(in_bus, sel);
        adv_rec    = pick(in_bus, nxt_idx);
        pend_rec   = pick(in_bus, pend_idx);
    end

    // Mode FSM together with the output register, dwell counter and pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_MAN;
            cnt       <= '0;
            pend_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            sel_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            overrun <= 1'b0;

            // Consumption; a capture below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_MAN: begin
                    if (load) begin
                        if (!sel_ok) begin
                            sel_err <= 1'b1;
                        end else if (open) begin
                            out_data  <= man_rec;
                            out_idx   <= sel;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    if (auto_en) begin
                        state <= S_AUTO;
                        cnt   <= '0;
                    end
                end

                S_AUTO: begin
                    if (!auto_en) begin
                        state <= S_MAN;
                    end else if (tick) begin
                        cnt <= '0;
                        if (open) begin
                            out_data  <= adv_rec;
                            out_idx   <= nxt_idx;
                            out_valid <= 1'b1;
                        end else begin
                            pend_idx <= nxt_idx;
                            state    <= S_STALL;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STALL: begin
                    // Counter stays frozen here; the advance is simply late.
                    if (!auto_en) begin
                        state <= S_MAN;
                    end else if (open) begin
                        out_data  <= pend_rec;
                        out_idx   <= pend_idx;
                        out_valid <= 1'b1;
                        state     <= S_AUTO;
                        cnt       <= '0;
                    end
                end

                default: begin
                    state <= S_MAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_select_seq.sv
// Bench for line_select_seq: a cycle-level reference model predicts the
// outputs after every edge and queues them; a monitor compares the DUT one
// time unit after each edge. Directed scenarios precede a random phase.
module tb_line_select_seq;

    localparam int W       = 77;
    localparam int N       = 13;
    localparam int SELW    = 4;
    localparam int DWELL_W = 16;
    localparam int EW      = 2 + 3 + SELW + W;

    localparam int M_MAN   = 0;
    localparam int M_AUTO  = 1;
    localparam int M_STALL = 2;

    logic                clk;
    logic                reset_n;
    logic [N*W-1:0]      in_bus;
    logic [SELW-1:0]     sel;
    logic                load;
    logic                auto_en;
    logic [DWELL_W-1:0]  dwell;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic                out_valid;
    logic [SELW-1:0]     out_idx;
    logic                sel_err;
    logic                overrun;
    logic [1:0]          state_dbg;

    logic [W-1:0]  chan [N];
    logic [EW-1:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    // model state
    int         m_mode = M_MAN;
    int         m_cnt  = 0;
    int         m_pend = 0;
    int         m_idx  = 0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [W-1:0] m_data = '0;

    line_select_seq #(.W(W), .N(N), .SELW(SELW), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_bus    (in_bus),
        .sel       (sel),
        .load      (load),
        .auto_en   (auto_en),
        .dwell     (dwell),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .sel_err   (sel_err),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural prediction of the outputs after the coming edge.
    task automatic model_step();
        logic op;
        logic cap;
        int   cidx;
        int   lim;
        if (!reset_n) begin
            m_mode = M_MAN; m_cnt = 0; m_pend = 0; m_idx = 0;
            m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_data = '0;
        end else begin
            op   = !m_valid || out_ready;
            cap  = 1'b0;
            cidx = 0;
            m_err = 1'b0;
            m_ovr = 1'b0;
            if (m_mode == M_MAN) begin
                if (load) begin
                    if (int'(sel) >= N) m_err = 1'b1;
                    else if (op) begin cap = 1'b1; cidx = int'(sel); end
                    else m_ovr = 1'b1;
                end
                if (auto_en) begin m_mode = M_AUTO; m_cnt = 0; end
            end else if (m_mode == M_AUTO) begin
                lim = (dwell == 0) ? 1 : int'(dwell);
                if (!auto_en) m_mode = M_MAN;
                else if (m_cnt >= lim - 1) begin
                    m_cnt = 0;
                    if (op) begin cap = 1'b1; cidx = (m_idx + 1) % N; end
                    else begin m_pend = (m_idx + 1) % N; m_mode = M_STALL; end
                end else m_cnt++;
            end else begin
                if (!auto_en) m_mode = M_MAN;
                else if (op) begin cap = 1'b1; cidx = m_pend; m_mode = M_AUTO; m_cnt = 0; end
            end
            if (cap) begin
                m_valid = 1'b1; m_idx = cidx; m_data = chan[cidx];
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        exp_q.push_back({2'(m_mode), m_err, m_ovr, m_valid, SELW'(m_idx), m_data});
    endtask

    // Driver: fresh channel data, predict, then advance one edge.
    task automatic step();
        for (int k = 0; k < N; k++) begin
            chan[k] = W'({$urandom(), $urandom(), $urandom()});
            in_bus[k*W +: W] = chan[k];
        end
        model_step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs with the oldest prediction.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state_dbg, sel_err, overrun, out_valid, out_idx, out_data};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle t=%0t got st=%0d err=%0b ovr=%0b v=%0b idx=%0d d=%0h expected st=%0d err=%0b ovr=%0b v=%0b idx=%0d d=%0h",
                         $time, g[EW-1 -: 2], g[EW-3], g[EW-4], g[EW-5], g[W +: SELW], g[W-1:0],
                         e[EW-1 -: 2], e[EW-3], e[EW-4], e[EW-5], e[W +: SELW], e[W-1:0]);
            end
        end
    end

    initial begin
        logic [W-1:0] d5;
        reset_n = 1'b0; sel = '0; load = 1'b0; auto_en = 1'b0;
        dwell = '0; out_ready = 1'b1; in_bus = '0;

        // reset
        repeat (3) step();
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_idx",   128'(out_idx),   128'(0));
        check("reset_data",  128'(out_data),  128'(0));
        check("reset_state", 128'(state_dbg), 128'(0));

        // first edge after release captures channel 5
        reset_n = 1'b1; load = 1'b1; sel = 4'd5; out_ready = 1'b1;
        step();
        check("load5_valid", 128'(out_valid), 128'(1));
        check("load5_idx",   128'(out_idx),   128'(5));
        check("load5_data",  128'(out_data),  128'(chan[5]));
        d5 = chan[5];

        // bad select while output held
        out_ready = 1'b0; sel = 4'd13;
        step();
        check("selerr_pulse", 128'(sel_err),   128'(1));
        check("selerr_valid", 128'(out_valid), 128'(1));
        check("selerr_data",  128'(out_data),  128'(d5));
        load = 1'b0;
        step();
        check("selerr_clear", 128'(sel_err), 128'(0));

        // blocked load
        load = 1'b1; sel = 4'd2;
        step();
        check("ovr_pulse", 128'(overrun), 128'(1));
        check("ovr_idx",   128'(out_idx), 128'(5));
        load = 1'b0; out_ready = 1'b1;
        step();
        check("ovr_clear",    128'(overrun),   128'(0));
        check("consume_valid", 128'(out_valid), 128'(0));

        // rotation 11 -> 12 -> 0 -> 1 at dwell 3
        load = 1'b1; sel = 4'd11;
        step();
        load = 1'b0; auto_en = 1'b1; dwell = 16'd3;
        step();
        repeat (3) step();
        check("rot_12", 128'(out_idx), 128'(12));
        repeat (3) step();
        check("rot_0", 128'(out_idx), 128'(0));
        repeat (3) step();
        check("rot_1",   128'(out_idx),   128'(1));
        check("rot_val", 128'(out_valid), 128'(1));

        // dwell 0: every cycle, then a 5-cycle stall
        dwell = 16'd0;
        step();
        check("fast_2", 128'(out_idx), 128'(2));
        out_ready = 1'b0;
        repeat (5) begin
            step();
            check("stall_idx", 128'(out_idx), 128'(2));
            check("stall_ovr", 128'(overrun), 128'(0));
        end
        check("stall_state", 128'(state_dbg), 128'(2));
        out_ready = 1'b1;
        step();
        check("stall_release", 128'(out_idx), 128'(3));

        // reset during stall
        out_ready = 1'b0;
        step();
        check("stall2_state", 128'(state_dbg), 128'(2));
        reset_n = 1'b0; auto_en = 1'b0;
        step();
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_idx",   128'(out_idx),   128'(0));
        check("rst_data",  128'(out_data),  128'(0));
        check("rst_state", 128'(state_dbg), 128'(0));
        reset_n = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_valid", 128'(out_valid), 128'(0));
        check("post_rst_pulse", 128'({sel_err, overrun}), 128'(0));

        // random phase
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            load      = ($urandom_range(0, 9) < 3);
            sel       = SELW'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 19) == 0) dwell = DWELL_W'($urandom_range(0, 4));
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
